// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and helpers for the UART transmit-side byte buffer.
package uart_tx_fifo_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StLaunch   = 2'd1,
        StWaitBusy = 2'd2,
        StWaitDone = 2'd3
    } tx_state_e;

    // Number of address bits needed to index `value` entries.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits;
        bits = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            bits++;
        end
        return bits;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Circular register-array FIFO with occupancy count and sticky overflow flag.
module uart_sync_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    rd_en,
    input  logic                    ovf_clr,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [clog2(DEPTH):0]   count,
    output logic                    overflow
);

    localparam int unsigned ADDR_W = clog2(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_bad_depth
        $error("uart_sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              push, pop;

    // Both decisions use the pre-edge count, so a full FIFO drops a push
    // even when a pop frees a slot on the same edge.
    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;

    assign rd_data  = mem[rd_ptr_q];
    assign count    = count_q;
    assign overflow = overflow_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A dropped push outranks a clear in the same cycle.
        if (wr_en && full) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage carries no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus launch sequencer feeding the UART transmitter start/busy handshake.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned BUSY_WAIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [BYTE_W-1:0]       wr_data,
    input  logic                    ovf_clr,
    input  logic                    tx_busy,
    output logic                    tx_start,
    output logic [BYTE_W-1:0]       tx_data,
    output logic                    full,
    output logic                    empty,
    output logic [clog2(DEPTH):0]   count,
    output logic                    overflow
);

    localparam int unsigned TIMER_W = clog2(BUSY_WAIT) + 1;
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BUSY_WAIT - 1);

    if (BUSY_WAIT < 1) begin : gen_bad_busy_wait
        $error("uart_tx_fifo: BUSY_WAIT must be at least 1");
    end

    tx_state_e          state_q, state_d;
    logic               tx_start_q, tx_start_d;
    logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               pop;
    logic [BYTE_W-1:0]  fifo_rd_data;
    logic               fifo_empty;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop),
        .ovf_clr  (ovf_clr),
        .rd_data  (fifo_rd_data),
        .full     (full),
        .empty    (fifo_empty),
        .count    (count),
        .overflow (overflow)
    );

    assign empty    = fifo_empty;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

    always_comb begin
        state_d    = state_q;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        timer_d    = timer_q;
        pop        = 1'b0;

        case (state_q)
            StIdle: begin
                if (!fifo_empty && !tx_busy) begin
                    pop        = 1'b1;
                    tx_data_d  = fifo_rd_data;
                    tx_start_d = 1'b1;
                    state_d    = StLaunch;
                end
            end
            StLaunch: begin
                tx_start_d = 1'b0;
                timer_d    = '0;
                state_d    = StWaitBusy;
            end
            StWaitBusy: begin
                // A transmitter that never acknowledges must not stall the queue.
                if (tx_busy) begin
                    state_d = StWaitDone;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                    if (timer_q == TIMER_LAST) begin
                        state_d = StIdle;
                    end
                end
            end
            StWaitDone: begin
                if (!tx_busy) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d    = StIdle;
                tx_start_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            timer_q    <= timer_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a behavioural transmitter busy model.
module tb_uart_tx_fifo;

    localparam int unsigned DEPTH     = 16;
    localparam int unsigned BUSY_WAIT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       ovf_clr = 1'b0;
    logic       tx_busy = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int launches = 0;
    logic [7:0] sb[$];

    bit busy_force = 1'b0;
    bit busy_dead  = 1'b0;
    int busy_len   = 2;
    int busy_cnt   = 0;
    bit prev_start = 1'b0;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .DEPTH     (DEPTH),
        .BUSY_WAIT (BUSY_WAIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .ovf_clr  (ovf_clr),
        .tx_busy  (tx_busy),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input bit accept);
        wr_en   = 1'b1;
        wr_data = b;
        if (accept) sb.push_back(b);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_launches(input int target, input int budget);
        int n = 0;
        while (launches < target && n < budget) begin
            tick();
            n++;
        end
        check("launch_count", launches, target);
    endtask

    // Monitor and transmitter model share one block so their ordering is fixed.
    always @(negedge clk) begin
        if (rst) begin
            tx_busy    = 1'b0;
            busy_cnt   = 0;
            prev_start = 1'b0;
        end else begin
            if (tx_start) begin
                launches++;
                check("start_while_busy", tx_busy, 0);
                check("start_one_cycle", prev_start, 0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_launch: got tx_data %0h expected no launch", tx_data);
                end else begin
                    check("launch_byte", tx_data, sb.pop_front());
                end
            end
            prev_start = tx_start;
            if (busy_force) begin
                tx_busy  = 1'b1;
                busy_cnt = 0;
            end else if (busy_cnt != 0) begin
                busy_cnt--;
                tx_busy = (busy_cnt != 0);
            end else if (tx_start && !busy_dead) begin
                tx_busy  = 1'b1;
                busy_cnt = busy_len;
            end else begin
                tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int gap;

        #1 rst = 1'b1;
        #1;
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);
        tick();
        rst = 1'b0;
        tick();

        // Single byte: launch two edges after the push, then silence.
        busy_len = 100;
        base = launches;
        push(8'hA5, 1'b1);
        check("single_count_after_push", count, 1);
        check("single_no_early_start", tx_start, 0);
        tick();
        check("single_start", tx_start, 1);
        check("single_data", tx_data, 8'hA5);
        repeat (110) tick();
        check("single_one_launch", launches, base + 1);
        check("single_empty", empty, 1);

        // Fill past capacity while the transmitter is busy.
        busy_len = 2;
        busy_force = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 17; i++) push(8'(i), i < 16);
        check("fill_full", full, 1);
        check("fill_count", count, 16);
        check("fill_overflow", overflow, 1);
        check("fill_not_empty", empty, 0);
        base = launches;
        busy_force = 1'b0;
        wait_launches(base + 16, 400);
        repeat (10) tick();
        check("drain_empty", empty, 1);
        check("drain_count", count, 0);
        check("overflow_sticky", overflow, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("overflow_cleared", overflow, 0);

        // Pointer wrap: 10 in/out, then 12 across the wrap point.
        busy_force = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 10; i++) push(8'h50 + 8'(i), 1'b1);
        check("wrap_count10", count, 10);
        base = launches;
        busy_force = 1'b0;
        wait_launches(base + 10, 300);
        busy_force = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 12; i++) push(8'h20 + 8'(i), 1'b1);
        check("wrap_count12", count, 12);
        base = launches;
        busy_force = 1'b0;
        wait_launches(base + 12, 300);
        repeat (10) tick();
        check("wrap_count_zero", count, 0);
        check("wrap_empty", empty, 1);

        // Push coinciding with the IDLE pop of the only stored byte.
        repeat (5) tick();
        base = launches;
        wr_en = 1'b1;
        wr_data = 8'h3B;
        sb.push_back(8'h3B);
        tick();
        check("simul_count_before", count, 1);
        wr_data = 8'h3C;
        sb.push_back(8'h3C);
        tick();
        wr_en = 1'b0;
        check("simul_count_held", count, 1);
        check("simul_start", tx_start, 1);
        check("simul_data", tx_data, 8'h3B);
        wait_launches(base + 2, 60);
        repeat (10) tick();
        check("simul_count_zero", count, 0);

        // Transmitter never acknowledges: sequencer must time out and move on.
        busy_dead = 1'b1;
        repeat (5) tick();
        base = launches;
        push(8'h61, 1'b1);
        push(8'h62, 1'b1);
        check("timeout_first_start", tx_start, 1);
        check("timeout_first_data", tx_data, 8'h61);
        gap = 0;
        do begin
            tick();
            gap++;
        end while (!tx_start && gap < 30);
        check("timeout_gap", gap, BUSY_WAIT + 2);
        check("timeout_second_data", tx_data, 8'h62);
        repeat (12) tick();
        busy_dead = 1'b0;
        check("timeout_launches", launches, base + 2);
        check("timeout_empty", empty, 1);

        // Reset while a launch pulse is high and the FIFO holds an overflowed load.
        busy_force = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 17; i++) push(8'h70 + 8'(i), i < 16);
        check("prereset_overflow", overflow, 1);
        busy_force = 1'b0;
        gap = 0;
        while (!tx_start && gap < 20) begin
            tick();
            gap++;
        end
        check("prereset_start", tx_start, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_tx_start", tx_start, 0);
        check("midrst_tx_data", tx_data, 8'h00);
        check("midrst_count", count, 0);
        check("midrst_empty", empty, 1);
        check("midrst_full", full, 0);
        check("midrst_overflow", overflow, 0);
        sb.delete();
        tick();
        rst = 1'b0;
        tick();
        base = launches;
        push(8'h7E, 1'b1);
        wait_launches(base + 1, 40);
        repeat (10) tick();
        check("postrst_empty", empty, 1);
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
